// File: rtl/place_pkg.sv
// Shared widths, capacity and update record for the placement-decision stage.
package place_pkg;

  localparam int STRIP_W    = 128;
  localparam int STRIP_ID_W = 4;
  localparam int OCC_W      = 8;
  localparam int DIM_W      = 5;
  localparam int N_SLOT     = 3;

  typedef logic [STRIP_ID_W-1:0] strip_id_t;
  typedef logic [OCC_W-1:0]      occ_t;
  typedef logic [DIM_W-1:0]      dim_t;

  typedef struct packed {
    strip_id_t strip;
    occ_t      occ;
  } occ_upd_t;

endpackage

// File: rtl/back_select_place_if.sv
// Candidate bundle in, placement result and occupancy write-back out.
interface back_select_place_if;
  import place_pkg::*;

  logic        valid_in;
  strip_id_t   str_id_1, str_id_2, str_id_3;
  occ_t        occ_width_1, occ_width_2, occ_width_3;
  dim_t        width_in, height_in;

  logic        place_valid, place_fail;
  strip_id_t   place_strip;
  occ_t        place_x;
  dim_t        place_width, place_height;
  logic        upd_en;
  strip_id_t   upd_strip;
  occ_t        upd_occ;
  logic [15:0] fail_count, place_count;

  modport master (
    output valid_in, str_id_1, str_id_2, str_id_3,
           occ_width_1, occ_width_2, occ_width_3, width_in, height_in,
    input  place_valid, place_fail, place_strip, place_x, place_width,
           place_height, upd_en, upd_strip, upd_occ, fail_count, place_count
  );

  modport slave (
    input  valid_in, str_id_1, str_id_2, str_id_3,
           occ_width_1, occ_width_2, occ_width_3, width_in, height_in,
    output place_valid, place_fail, place_strip, place_x, place_width,
           place_height, upd_en, upd_strip, upd_occ, fail_count, place_count
  );
endinterface

// File: rtl/back_select_place_occ_bypass.sv
// occ_bypass: history of recent occupancy updates plus the live S2 update,
// used to correct stale occupancy reads for three lookup ports.
module occ_bypass
  import place_pkg::*;
#(
  parameter int BYP_DEPTH = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fwd_en,
  input  occ_upd_t               fwd,
  input  strip_id_t [N_SLOT-1:0] lk_id,
  input  occ_t      [N_SLOT-1:0] lk_occ,
  output occ_t      [N_SLOT-1:0] occ_c
);

  occ_upd_t hist_reg     [BYP_DEPTH];
  logic     hist_vld_reg [BYP_DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BYP_DEPTH; i++) begin
        hist_vld_reg[i] <= 1'b0;
        hist_reg[i]     <= '0;
      end
    end else if (fwd_en) begin
      hist_vld_reg[0] <= 1'b1;
      hist_reg[0]     <= fwd;
      for (int i = 1; i < BYP_DEPTH; i++) begin
        hist_vld_reg[i] <= hist_vld_reg[i-1];
        hist_reg[i]     <= hist_reg[i-1];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_SLOT; gi++) begin : g_lookup
      occ_t sel;
      // Walk oldest to newest so the newest match wins; the S2 update beats all history.
      always_comb begin
        sel = lk_occ[gi];
        if (lk_id[gi] != '0) begin
          for (int i = BYP_DEPTH - 1; i >= 0; i--) begin
            if (hist_vld_reg[i] && hist_reg[i].strip == lk_id[gi]) sel = hist_reg[i].occ;
          end
          if (fwd_en && fwd.strip == lk_id[gi]) sel = fwd.occ;
        end
      end
      assign occ_c[gi] = sel;
    end
  endgenerate

endmodule

// File: rtl/back_select_place.sv
// Best-fit strip selection with in-flight occupancy forwarding.
// Optional statistics counters enabled by defining PLACE_STATS_EN.
module back_select_place #(
  parameter int STRIP_W   = place_pkg::STRIP_W,
  parameter int BYP_DEPTH = 3
) (
  input logic          clk,
  input logic          rst,
  back_select_place_if.slave bus
);
  import place_pkg::*;

  localparam logic [OCC_W:0] CAP = (OCC_W+1)'(STRIP_W);

  logic                   s1_valid_reg;
  strip_id_t [N_SLOT-1:0] s1_id_reg;
  occ_t      [N_SLOT-1:0] s1_occ_reg;
  dim_t                   s1_width_reg, s1_height_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg  <= 1'b0;
      s1_id_reg     <= '0;
      s1_occ_reg    <= '0;
      s1_width_reg  <= '0;
      s1_height_reg <= '0;
    end else begin
      s1_valid_reg  <= bus.valid_in;
      s1_id_reg     <= {bus.str_id_3, bus.str_id_2, bus.str_id_1};
      s1_occ_reg    <= {bus.occ_width_3, bus.occ_width_2, bus.occ_width_1};
      s1_width_reg  <= bus.width_in;
      s1_height_reg <= bus.height_in;
    end
  end

  logic      place_valid_reg, place_fail_reg, upd_en_reg;
  strip_id_t place_strip_reg;
  occ_t      place_x_reg, upd_occ_reg;
  dim_t      place_width_reg, place_height_reg;

  occ_t [N_SLOT-1:0] occ_c;
  logic [N_SLOT-1:0] fit;

  occ_bypass #(.BYP_DEPTH(BYP_DEPTH)) u_bypass (
    .clk    (clk),
    .rst    (rst),
    .fwd_en (upd_en_reg),
    .fwd    ({place_strip_reg, upd_occ_reg}),
    .lk_id  (s1_id_reg),
    .lk_occ (s1_occ_reg),
    .occ_c  (occ_c)
  );

  genvar gi;
  generate
    for (gi = 0; gi < N_SLOT; gi++) begin : g_fit
      assign fit[gi] = (s1_id_reg[gi] != '0) && (s1_width_reg != '0) &&
                       (({1'b0, occ_c[gi]} + (OCC_W+1)'(s1_width_reg)) <= CAP);
    end
  endgenerate

  logic      found;
  strip_id_t best_strip;
  occ_t      best_occ;

  // Strict compare keeps the lowest slot on equal occupancy.
  always_comb begin
    found      = 1'b0;
    best_strip = '0;
    best_occ   = '0;
    for (int i = 0; i < N_SLOT; i++) begin
      if (fit[i] && (!found || occ_c[i] > best_occ)) begin
        found      = 1'b1;
        best_strip = s1_id_reg[i];
        best_occ   = occ_c[i];
      end
    end
  end

  logic hit;
  assign hit = s1_valid_reg && found;

  always_ff @(posedge clk) begin
    if (rst) begin
      place_valid_reg  <= 1'b0;
      place_fail_reg   <= 1'b0;
      place_strip_reg  <= '0;
      place_x_reg      <= '0;
      place_width_reg  <= '0;
      place_height_reg <= '0;
      upd_en_reg       <= 1'b0;
      upd_occ_reg      <= '0;
    end else begin
      place_valid_reg  <= s1_valid_reg;
      place_fail_reg   <= s1_valid_reg && !found;
      place_strip_reg  <= hit ? best_strip : '0;
      place_x_reg      <= hit ? best_occ : '0;
      place_width_reg  <= s1_valid_reg ? s1_width_reg : '0;
      place_height_reg <= s1_valid_reg ? s1_height_reg : '0;
      upd_en_reg       <= hit;
      upd_occ_reg      <= hit ? best_occ + occ_t'(s1_width_reg) : '0;
    end
  end

  assign bus.place_valid  = place_valid_reg;
  assign bus.place_fail   = place_fail_reg;
  assign bus.place_strip  = place_strip_reg;
  assign bus.place_x      = place_x_reg;
  assign bus.place_width  = place_width_reg;
  assign bus.place_height = place_height_reg;
  assign bus.upd_en       = upd_en_reg;
  assign bus.upd_strip    = place_strip_reg;
  assign bus.upd_occ      = upd_occ_reg;

`ifdef PLACE_STATS_EN
  logic [15:0] fail_cnt_reg, place_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      fail_cnt_reg  <= '0;
      place_cnt_reg <= '0;
    end else if (place_valid_reg) begin
      if (place_fail_reg && fail_cnt_reg != 16'hFFFF) fail_cnt_reg <= fail_cnt_reg + 16'd1;
      if (!place_fail_reg && place_cnt_reg != 16'hFFFF) place_cnt_reg <= place_cnt_reg + 16'd1;
    end
  end

  assign bus.fail_count  = fail_cnt_reg;
  assign bus.place_count = place_cnt_reg;
`else
  assign bus.fail_count  = '0;
  assign bus.place_count = '0;
`endif

endmodule

// File: tb/tb_back_select_place.sv
// Bench for back_select_place: directed scenarios plus random bundles against
// a model that keeps a plain list of successful placements.
module tb_back_select_place;
  import place_pkg::*;

  localparam int SW = 128;
  localparam int BD = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  back_select_place_if bus();

  back_select_place #(.STRIP_W(SW), .BYP_DEPTH(BD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit valid;
    bit fail;
    int strip;
    int x;
    int w;
    int h;
    int uocc;
  } exp_t;

  exp_t exp_d1, exp_d2;
  int   succ_strip[$];
  int   succ_occ[$];
  int   checks = 0;
  int   errors = 0;
  int   cnt_fail = 0;
  int   cnt_place = 0;
  int   tcount = 0;

  // A stale read is fixed by the newest earlier placement on that strip, provided it is
  // among the last BD placements, or the placement decided in the immediately prior cycle.
  function automatic int corrected(int id, int raw, bit prev_ok);
    int n, lo;
    if (id == 0) return raw;
    n  = prev_ok ? BD + 1 : BD;
    lo = succ_strip.size() - n;
    if (lo < 0) lo = 0;
    for (int i = succ_strip.size() - 1; i >= lo; i--)
      if (succ_strip[i] == id) return succ_occ[i];
    return raw;
  endfunction

  function automatic exp_t model(bit v, int i1, int i2, int i3, int o1, int o2, int o3,
                                 int w, int h);
    exp_t e;
    int   ids[3];
    int   occs[3];
    int   best, c;
    bit   prev_ok;
    e = '{default: 0};
    if (!v) return e;
    ids  = '{i1, i2, i3};
    occs = '{o1, o2, o3};
    prev_ok = exp_d1.valid && !exp_d1.fail;
    best = -1;
    for (int i = 0; i < 3; i++) begin
      c = corrected(ids[i], occs[i], prev_ok);
      if (ids[i] != 0 && w != 0 && c + w <= SW && (best < 0 || c > e.x)) begin
        best    = i;
        e.x     = c;
        e.strip = ids[i];
      end
    end
    e.valid = 1'b1;
    e.w = w;
    e.h = h;
    if (best < 0) begin
      e.fail = 1'b1;
      e.x = 0;
      e.strip = 0;
    end else begin
      e.uocc = e.x + w;
      succ_strip.push_back(e.strip);
      succ_occ.push_back(e.uocc);
    end
    return e;
  endfunction

  task automatic step(bit v, int i1, int i2, int i3, int o1, int o2, int o3,
                      int w, int h, bit r);
    logic [36:0] got, want;
    logic [31:0] cgot, cwant;
    int ef, ep;
    @(negedge clk);
    tcount++;
    got  = {bus.place_valid, bus.place_fail, bus.place_strip, bus.place_x, bus.place_width,
            bus.place_height, bus.upd_en, bus.upd_strip, bus.upd_occ};
    want = {exp_d2.valid, exp_d2.fail, 4'(exp_d2.strip), 8'(exp_d2.x), 5'(exp_d2.w),
            5'(exp_d2.h), (exp_d2.valid && !exp_d2.fail), 4'(exp_d2.strip), 8'(exp_d2.uocc)};
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL outputs t=%0d got=%h expected=%h", tcount, got, want);
    end else if (exp_d2.valid) begin
      $display("t=%0d place strip=%0d x=%0d fail=%0d upd_occ=%0d", tcount,
               bus.place_strip, bus.place_x, bus.place_fail, bus.upd_occ);
    end
`ifdef PLACE_STATS_EN
    ef = cnt_fail;
    ep = cnt_place;
`else
    ef = 0;
    ep = 0;
`endif
    cgot  = {bus.fail_count, bus.place_count};
    cwant = {16'(ef), 16'(ep)};
    checks++;
    if (cgot !== cwant) begin
      errors++;
      $display("FAIL counters t=%0d got fail=%0d place=%0d expected fail=%0d place=%0d",
               tcount, bus.fail_count, bus.place_count, ef, ep);
    end
    if (exp_d2.valid) begin
      if (exp_d2.fail) cnt_fail = (cnt_fail < 65535) ? cnt_fail + 1 : cnt_fail;
      else cnt_place = (cnt_place < 65535) ? cnt_place + 1 : cnt_place;
    end

    exp_d2 = exp_d1;
    if (r) begin
      exp_d2 = '{default: 0};
      exp_d1 = '{default: 0};
      cnt_fail = 0;
      cnt_place = 0;
      succ_strip.delete();
      succ_occ.delete();
    end else begin
      exp_d1 = model(v, i1, i2, i3, o1, o2, o3, w, h);
    end

    rst             = r;
    bus.valid_in    = v;
    bus.str_id_1    = strip_id_t'(i1);
    bus.str_id_2    = strip_id_t'(i2);
    bus.str_id_3    = strip_id_t'(i3);
    bus.occ_width_1 = occ_t'(o1);
    bus.occ_width_2 = occ_t'(o2);
    bus.occ_width_3 = occ_t'(o3);
    bus.width_in    = dim_t'(w);
    bus.height_in   = dim_t'(h);
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_reset();
    do_reset();
    idle(3);
  endtask

  task automatic test_single_fit();
    do_reset();
    step(1, 2, 0, 0, 40, 0, 0, 10, 3, 0);
    idle(3);
  endtask

  task automatic test_best_fit();
    do_reset();
    step(1, 1, 2, 3, 100, 60, 125, 20, 7, 0);
    step(1, 4, 5, 4, 50, 50, 50, 8, 2, 0);
    idle(3);
  endtask

  task automatic test_exact_fill_fail();
    do_reset();
    step(1, 9, 0, 0, 118, 0, 0, 10, 1, 0);
    step(1, 1, 2, 3, 128, 128, 128, 5, 1, 0);
    step(1, 6, 0, 0, 0, 0, 0, 0, 4, 0);
    idle(3);
  endtask

  task automatic test_back_to_back();
    do_reset();
    step(1, 5, 0, 0, 0, 0, 0, 16, 2, 0);
    step(1, 5, 0, 0, 0, 0, 0, 16, 2, 0);
    step(1, 0, 5, 0, 0, 0, 0, 16, 2, 0);
    idle(3);
  endtask

  task automatic test_history();
    do_reset();
    step(1, 7, 0, 0, 20, 0, 0, 10, 1, 0);
    step(1, 1, 0, 0, 0, 0, 0, 5, 1, 0);
    step(1, 2, 0, 0, 0, 0, 0, 5, 1, 0);
    step(1, 7, 0, 0, 0, 0, 0, 1, 1, 0);
    idle(3);
    do_reset();
    step(1, 7, 0, 0, 20, 0, 0, 10, 1, 0);
    for (int k = 1; k <= BD + 1; k++) step(1, k, 0, 0, 0, 0, 0, 5, 1, 0);
    step(1, 7, 0, 0, 0, 0, 0, 1, 1, 0);
    idle(3);
  endtask

  task automatic test_reset_midstream();
    do_reset();
    step(1, 3, 0, 0, 10, 0, 0, 4, 4, 0);
    step(1, 4, 0, 0, 20, 0, 0, 6, 6, 0);
    step(1, 3, 0, 0, 10, 0, 0, 4, 4, 1);
    idle(4);
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      step(($urandom % 4) != 0, $urandom % 6, $urandom % 6, $urandom % 6,
           $urandom_range(0, 140), $urandom_range(0, 140), $urandom_range(0, 140),
           $urandom % 32, $urandom % 32, ($urandom % 60) == 0);
    end
    idle(3);
  endtask

  initial begin
    exp_d1 = '{default: 0};
    exp_d2 = '{default: 0};
    rst = 1'b1;
    bus.valid_in = 1'b0;
    bus.str_id_1 = '0;
    bus.str_id_2 = '0;
    bus.str_id_3 = '0;
    bus.occ_width_1 = '0;
    bus.occ_width_2 = '0;
    bus.occ_width_3 = '0;
    bus.width_in = '0;
    bus.height_in = '0;
    repeat (2) @(posedge clk);
    test_reset();
    test_single_fit();
    test_best_fit();
    test_exact_fill_fail();
    test_back_to_back();
    test_history();
    test_reset_midstream();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/back_select_place.md
# back_select_place

Placement-decision stage directly downstream of the front-end row-find/occupancy-read stage. It takes up to three candidate strip IDs with their occupied widths, corrects stale occupancy with recent in-flight updates, and picks the best-fit strip. It then emits the placement (strip, x-offset) and a write-back update for the occupancy table. It closes the placement loop: its update port feeds the front-end's occupied-width array.

## Interface
Parameters:
- `STRIP_W`, default 128: strip capacity in width units; occupancy is full at this value.
- `BYP_DEPTH`, default 3: number of most-recent updates held for forwarding. Must be at least the front-end read-to-decision latency.

Ports:
- `clk` in 1: single clock; all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `valid_in` in 1: candidate bundle valid this cycle.
- `str_id_1`, `str_id_2`, `str_id_3` in 4: candidate strip IDs; 0 = no candidate in that slot.
- `occ_width_1`, `occ_width_2`, `occ_width_3` in 8: occupied width of each candidate, as read by the front-end (possibly stale).
- `width_in` in 5: program width.
- `height_in` in 5: program height.
- `place_valid` out 1: placement result valid (one cycle per input).
- `place_fail` out 1: with `place_valid`, no candidate fits.
- `place_strip` out 4: chosen strip ID; 0 on fail.
- `place_x` out 8: x-offset, equal to the corrected occupancy of the chosen strip; 0 on fail.
- `place_width` out 5: `width_in`, carried through.
- `place_height` out 5: `height_in`, carried through.
- `upd_en` out 1: occupancy write-back strobe.
- `upd_strip` out 4: strip to write.
- `upd_occ` out 8: new occupancy value.
- `fail_count` out 16: failed placements (stats build only).
- `place_count` out 16: successful placements (stats build only).

## Operation
- **S1 (registered inputs):** register `valid_in`, the three ID/occ pairs, `width_in` and `height_in`.
- **Forwarding:** for each slot, corrected occ = the newest matching entry from {S2 update being issued this cycle, bypass history newest→oldest}. If no entry matches, use the input occ. An ID of 0 never matches.
- **Fit test:** 9-bit sum `occ_c + width <= STRIP_W`, requiring ID ≠ 0 and width ≠ 0.
- **Selection:** among slots that fit, take the largest corrected occ (tightest fit). Ties go to the lowest slot index. If the same ID appears in multiple slots, they are evaluated identically and the lowest index wins.
- **S2 (registered result):**
  - On success: `place_x` = occ_c, `upd_occ` = occ_c + width (≤ `STRIP_W`), `upd_en`=1.
  - On fail: `place_fail`=1, `upd_en`=0, `place_strip`=0, `place_x`=0.
- **Bypass history:** shift register of `{strip, occ}` pairs, depth `BYP_DEPTH`. It is pushed only when `upd_en`=1 and holds its value otherwise.

## Timing
- Latency: 2 cycles from `valid_in` to `place_valid`. `upd_en`, `upd_strip` and `upd_occ` are coincident with `place_valid`.
- Throughput: one bundle per cycle, no stall, no backpressure.
- Back-to-back bundles targeting the same strip:
  - The second bundle sees the first bundle's update via the S2 forward path (zero-bubble).
  - Updates up to `BYP_DEPTH` placements old are forwarded from the history.
- Reset, on the clock edge with `rst`=1:
  - All outputs go to 0, including both counters.
  - S1/S2 valids clear and the bypass history is invalidated.
  - Any in-flight bundle is dropped and produces no `upd_en`.
- `valid_in`=0: S1 holds nothing valid, and two cycles later `place_valid`=0 and `upd_en`=0.
- Boundary: occ = `STRIP_W` never fits a nonzero width. An exact fill (occ + width = `STRIP_W`) fits.

## Configuration
- `PLACE_STATS_EN` defined:
  - `fail_count` increments on `place_valid & place_fail`.
  - `place_count` increments on `place_valid & ~place_fail`.
  - Both saturate at 16'hFFFF and clear on `rst`.
- `PLACE_STATS_EN` undefined: no counter logic; both outputs are tied to 0.

## Structure
- Package `place_pkg`:
  - Constants: `STRIP_W`, `STRIP_ID_W` = 4, `OCC_W` = 8, `DIM_W` = 5.
  - Typedefs: `strip_id_t`, `occ_t`, and struct `occ_upd_t {strip, occ}`.
- Sub-module `occ_bypass`:
  - Holds the `BYP_DEPTH` history plus the S2 forward input.
  - Takes 3 lookup ports (ID, raw occ) and returns the corrected occ for each.

## Test plan
- **Single fit:** ids (2,0,0), occ (40,–,–), width 10 → 2 cycles later `place_strip`=2, `place_x`=40, `upd_occ`=50.
- **Best fit:** ids (1,2,3), occ (100,60,125), width 20 → strip 1, x=100, `upd_occ`=120. Strip 3 is rejected because 145 > 128.
- **Exact fill and fail:**
  - occ 118, width 10 → success, `upd_occ`=128.
  - occ 128 in all slots → `place_fail`=1, `upd_en`=0, and `fail_count` increments (stats build).
- **Back-to-back hazard:** two consecutive bundles, both ids (5,0,0) with stale occ 0 and width 16 → x=0 then x=16, `upd_occ` 16 then 32.
- **History forward:** strip 7 updated to 30, then 2 unrelated placements, then a bundle with stale occ 0 for strip 7 → x=30. With `BYP_DEPTH`+1 intervening placements, the stale value is used.
- **Reset mid-stream:** assert `rst` one cycle after `valid_in` → no `place_valid` or `upd_en` from that bundle; all outputs 0 next cycle.
